// File: rtl/exec_issue_ctrl_if.sv
// Bus between decode, the issue controller and the execute stage: instruction offer,
// unit-availability feedback, and the issued instruction fields.
interface exec_issue_ctrl_if #(
  parameter int ROB_SIZE      = 4,
  parameter int DEST_REG_SIZE = 5,
  parameter int PAYLOAD_WIDTH = 128,
  parameter int LAT_WIDTH     = 4
);
  // Decode-side instruction offer
  logic                     in_valid;
  logic                     in_ready;
  logic [2:0]               in_func_select;
  logic [LAT_WIDTH-1:0]     in_latency;
  logic [ROB_SIZE-1:0]      in_rob_entry;
  logic [DEST_REG_SIZE-1:0] in_dest_reg;
  logic [PAYLOAD_WIDTH-1:0] in_payload;

  // Execute-stage feedback and pipeline control
  logic [3:0]               alu_free;
  logic                     mem_full;
  logic                     flush;

  // Issued instruction
  logic [2:0]               func_select;
  logic [LAT_WIDTH-1:0]     latency_counter;
  logic [ROB_SIZE-1:0]      rob_entry;
  logic [DEST_REG_SIZE-1:0] dest_reg;
  logic [PAYLOAD_WIDTH-1:0] payload;
  logic                     ins_nop;
  logic [15:0]              stall_cycles;

  modport master (
    output in_valid, in_func_select, in_latency, in_rob_entry, in_dest_reg, in_payload,
    output alu_free, mem_full, flush,
    input  in_ready, func_select, latency_counter, rob_entry, dest_reg, payload,
    input  ins_nop, stall_cycles
  );

  modport slave (
    input  in_valid, in_func_select, in_latency, in_rob_entry, in_dest_reg, in_payload,
    input  alu_free, mem_full, flush,
    output in_ready, func_select, latency_counter, rob_entry, dest_reg, payload,
    output ins_nop, stall_cycles
  );
endinterface

// File: rtl/exec_issue_ctrl.sv
// In-order issue controller: buffers decoded instructions and issues the FIFO head to its
// functional unit when that unit can accept it, covering multi-cycle unit occupancy locally.
module exec_issue_ctrl #(
  parameter int         ROB_SIZE      = 4,
  parameter int         DEST_REG_SIZE = 5,
  parameter int         PAYLOAD_WIDTH = 128,
  parameter int         NUM_ALU       = 5,
  parameter logic [2:0] DUMMY_ALU     = 3'b101,
  parameter int         FIFO_DEPTH    = 4,
  parameter int         LAT_WIDTH     = 4
) (
  input logic              clk,
  input logic              reset,
  exec_issue_ctrl_if.slave bus
);

  localparam int               PTR_W     = $clog2(FIFO_DEPTH);
  localparam int               BUSY_W    = LAT_WIDTH + 1;
  localparam logic [PTR_W:0]   DEPTH_CNT = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [2:0]       NOP_BASE  = 3'(NUM_ALU);
  localparam logic [2:0]       UNIT_SINT = 3'd0;
  localparam logic [2:0]       UNIT_FP   = 3'd1;
  localparam logic [2:0]       UNIT_CINT = 3'd2;
  localparam logic [2:0]       UNIT_PRED = 3'd3;
  localparam logic [2:0]       UNIT_MEM  = 3'd4;

  typedef struct packed {
    logic [2:0]               func;
    logic [LAT_WIDTH-1:0]     lat;
    logic [ROB_SIZE-1:0]      rob;
    logic [DEST_REG_SIZE-1:0] dest;
    logic [PAYLOAD_WIDTH-1:0] payload;
  } entry_t;

  // Instruction buffer
  entry_t            fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W:0]    count;

  // Remaining occupancy of the multi-cycle units (FP and complex int)
  logic [BUSY_W-1:0] busy_fp;
  logic [BUSY_W-1:0] busy_cint;
  logic [15:0]       stall_q;

  // Registered issue outputs
  logic [2:0]               func_q;
  logic [LAT_WIDTH-1:0]     lat_q;
  logic [ROB_SIZE-1:0]      rob_q;
  logic [DEST_REG_SIZE-1:0] dest_q;
  logic [PAYLOAD_WIDTH-1:0] payload_q;
  logic                     nop_q;

  // Head decode and handshake
  entry_t            head;
  entry_t            in_entry;
  logic              in_ready_w;
  logic              head_valid;
  logic              head_is_nop;
  logic              head_eligible;
  logic              issue;
  logic              push;
  logic [BUSY_W-1:0] busy_load;

  assign in_ready_w = (count < DEPTH_CNT);

  always_comb begin
    // NOTE: every signal gets a default before any branch, so no latch can be inferred.
    head_eligible = 1'b0;
    in_entry      = '{func:    bus.in_func_select,
                      lat:     bus.in_latency,
                      rob:     bus.in_rob_entry,
                      dest:    bus.in_dest_reg,
                      payload: bus.in_payload};
    head          = fifo_mem[rd_ptr];
    head_valid    = (count != '0);
    head_is_nop   = (head.func >= NOP_BASE);

    case (head.func)
      UNIT_SINT: head_eligible = bus.alu_free[0];
      UNIT_FP:   head_eligible = bus.alu_free[1] && (busy_fp == '0);
      UNIT_CINT: head_eligible = bus.alu_free[2] && (busy_cint == '0);
      UNIT_PRED: head_eligible = bus.alu_free[3];
      UNIT_MEM:  head_eligible = !bus.mem_full;
      default:   head_eligible = 1'b1;
    endcase

    issue = head_valid && head_eligible && !bus.flush;
    push  = bus.in_valid && in_ready_w && !bus.flush;

    // A zero latency still occupies the unit for one cycle; +1 covers the free-flag lag.
    if (head.lat == '0) busy_load = BUSY_W'(2);
    else                busy_load = BUSY_W'(head.lat) + BUSY_W'(1);
  end

  // NOTE: buffer storage has no reset; an entry is only ever read while count says it is valid.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= in_entry;
  end

  // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (bus.flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)  wr_ptr <= wr_ptr + 1'b1;
      if (issue) rd_ptr <= rd_ptr + 1'b1;
      case ({push, issue})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Occupancy keeps counting through a flush: instructions already in the units stay in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_fp   <= '0;
      busy_cint <= '0;
    end else begin
      if (issue && head.func == UNIT_FP) busy_fp <= busy_load;
      else if (busy_fp != '0)            busy_fp <= busy_fp - 1'b1;

      if (issue && head.func == UNIT_CINT) busy_cint <= busy_load;
      else if (busy_cint != '0)            busy_cint <= busy_cint - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q <= '0;
    end else if (head_valid && !head_eligible && stall_q != 16'hFFFF) begin
      stall_q <= stall_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      func_q    <= DUMMY_ALU;
      nop_q     <= 1'b1;
      lat_q     <= '0;
      rob_q     <= '0;
      dest_q    <= '0;
      payload_q <= '0;
    end else if (issue) begin
      func_q    <= head_is_nop ? DUMMY_ALU : head.func;
      nop_q     <= head_is_nop;
      lat_q     <= head.lat;
      rob_q     <= head.rob;
      dest_q    <= head.dest;
      payload_q <= head.payload;
    end else begin
      func_q    <= DUMMY_ALU;
      nop_q     <= 1'b1;
      lat_q     <= '0;
      rob_q     <= '0;
      dest_q    <= '0;
      payload_q <= '0;
    end
  end

  assign bus.in_ready        = in_ready_w;
  assign bus.func_select     = func_q;
  assign bus.ins_nop         = nop_q;
  assign bus.latency_counter = lat_q;
  assign bus.rob_entry       = rob_q;
  assign bus.dest_reg        = dest_q;
  assign bus.payload         = payload_q;
  assign bus.stall_cycles    = stall_q;

endmodule

// File: tb/tb_exec_issue_ctrl.sv
// Self-checking bench for exec_issue_ctrl: directed scenarios plus randomized traffic
// compared against a queue-based model that tracks unit reuse by edge number.
module tb_exec_issue_ctrl;

  localparam int         ROB_SIZE      = 4;
  localparam int         DEST_REG_SIZE = 5;
  localparam int         PAYLOAD_WIDTH = 128;
  localparam int         LAT_WIDTH     = 4;
  localparam int         FIFO_DEPTH    = 4;
  localparam logic [2:0] DUMMY         = 3'b101;

  typedef struct {
    logic [2:0]   func;
    logic [3:0]   lat;
    logic [3:0]   rob;
    logic [4:0]   dest;
    logic [127:0] payload;
  } ins_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  exec_issue_ctrl_if #(.ROB_SIZE(ROB_SIZE), .DEST_REG_SIZE(DEST_REG_SIZE),
                       .PAYLOAD_WIDTH(PAYLOAD_WIDTH), .LAT_WIDTH(LAT_WIDTH)) bus ();

  exec_issue_ctrl #(.ROB_SIZE(ROB_SIZE), .DEST_REG_SIZE(DEST_REG_SIZE),
                    .PAYLOAD_WIDTH(PAYLOAD_WIDTH), .NUM_ALU(5), .DUMMY_ALU(DUMMY),
                    .FIFO_DEPTH(FIFO_DEPTH), .LAT_WIDTH(LAT_WIDTH))
    dut (.clk(clk), .reset(reset), .bus(bus));

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: program-order queue, earliest edge at which units 1/2 may be reused
  ins_t         mq[$];
  int           edge_n = 0;
  int           next_ok[8];
  int           m_stall;
  logic [2:0]   e_func;
  logic         e_nop;
  logic [3:0]   e_lat;
  logic [3:0]   e_rob;
  logic [4:0]   e_dest;
  logic [127:0] e_payload;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  function automatic bit m_elig(ins_t h);
    case (h.func)
      3'd0:       return bus.alu_free[0];
      3'd1, 3'd2: return bus.alu_free[h.func] && (edge_n >= next_ok[h.func]);
      3'd3:       return bus.alu_free[3];
      3'd4:       return !bus.mem_full;
      default:    return 1'b1;
    endcase
  endfunction

  task automatic model_reset();
    mq.delete();
    m_stall = 0;
    foreach (next_ok[i]) next_ok[i] = 0;
    e_func = DUMMY; e_nop = 1'b1; e_lat = '0; e_rob = '0; e_dest = '0; e_payload = '0;
  endtask

  // Advance the model over the coming edge using the currently driven inputs, then clock.
  task automatic tick();
    bit   ready;
    bit   el;
    ins_t h;
    ready = (mq.size() < FIFO_DEPTH);
    el    = 1'b0;
    if (mq.size() > 0) begin
      h  = mq[0];
      el = m_elig(h);
      if (!el && m_stall < 65535) m_stall++;
    end
    e_func = DUMMY; e_nop = 1'b1; e_lat = '0; e_rob = '0; e_dest = '0; e_payload = '0;
    if (bus.flush) begin
      mq.delete();
    end else begin
      if (mq.size() > 0 && el) begin
        void'(mq.pop_front());
        e_nop     = (h.func > 3'd4);
        e_func    = e_nop ? DUMMY : h.func;
        e_lat     = h.lat;
        e_rob     = h.rob;
        e_dest    = h.dest;
        e_payload = h.payload;
        if (h.func == 3'd1 || h.func == 3'd2)
          next_ok[h.func] = edge_n + ((h.lat == 0) ? 1 : int'(h.lat)) + 2;
      end
      if (bus.in_valid && ready)
        mq.push_back('{bus.in_func_select, bus.in_latency, bus.in_rob_entry,
                       bus.in_dest_reg, bus.in_payload});
    end
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  task automatic idle_inputs();
    bus.in_valid = 1'b0; bus.in_func_select = '0; bus.in_latency = '0;
    bus.in_rob_entry = '0; bus.in_dest_reg = '0; bus.in_payload = '0;
    bus.alu_free = 4'hF; bus.mem_full = 1'b0; bus.flush = 1'b0;
  endtask

  task automatic set_in(input logic v, input logic [2:0] f, input logic [3:0] l,
                        input logic [3:0] r, input logic [4:0] d);
    bus.in_valid = v; bus.in_func_select = f; bus.in_latency = l;
    bus.in_rob_entry = r; bus.in_dest_reg = d;
    bus.in_payload = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic apply_reset();
    idle_inputs();
    reset = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({bus.func_select, bus.ins_nop, bus.in_ready, bus.latency_counter, bus.rob_entry,
         bus.dest_reg, bus.stall_cycles} !== {DUMMY, 1'b1, 1'b1, 4'd0, 4'd0, 5'd0, 16'd0}) begin
      $display("FAIL reset_ctrl: got func=%0d nop=%0d rdy=%0d lat=%0d rob=%0d dest=%0d stall=%0d, expected 5 1 1 0 0 0 0",
               bus.func_select, bus.ins_nop, bus.in_ready, bus.latency_counter, bus.rob_entry,
               bus.dest_reg, bus.stall_cycles);
    end else n_pass++;
    n_checks++;
    if (bus.payload !== 128'd0) $display("FAIL reset_payload: got %h expected 0", bus.payload);
    else n_pass++;
    reset = 1'b1;
  endtask

  task automatic test_basic_issue();
    apply_reset();
    set_in(1'b1, 3'd0, 4'd1, 4'd3, 5'd7);
    tick();
    bus.in_valid = 1'b0;
    n_checks++;
    if (bus.ins_nop !== 1'b1) $display("FAIL basic_no_bypass: got nop=%0d expected 1", bus.ins_nop);
    else n_pass++;
    tick();
    n_checks++;
    if ({bus.func_select, bus.rob_entry, bus.dest_reg, bus.ins_nop} !== {3'd0, 4'd3, 5'd7, 1'b0})
      $display("FAIL basic_issue: got func=%0d rob=%0d dest=%0d nop=%0d expected 0 3 7 0",
               bus.func_select, bus.rob_entry, bus.dest_reg, bus.ins_nop);
    else n_pass++;
    n_checks++;
    if (bus.payload !== e_payload) $display("FAIL basic_payload: got %h expected %h", bus.payload, e_payload);
    else n_pass++;
    tick();
    n_checks++;
    if ({bus.ins_nop, bus.func_select} !== {1'b1, DUMMY})
      $display("FAIL basic_after: got nop=%0d func=%0d expected 1 5", bus.ins_nop, bus.func_select);
    else n_pass++;
  endtask

  task automatic spacing_run(input logic [2:0] f, input logic [3:0] l,
                             input int exp_second, input int exp_stall);
    int iss[$];
    apply_reset();
    for (int k = 0; k < 12; k++) begin
      if (k == 0)      set_in(1'b1, f, l, 4'd1, 5'd1);
      else if (k == 1) set_in(1'b1, f, l, 4'd2, 5'd2);
      else             bus.in_valid = 1'b0;
      tick();
      if (bus.ins_nop === 1'b0) iss.push_back(k);
    end
    n_checks++;
    if (iss.size() != 2 || iss[0] != 1 || iss[1] != exp_second)
      $display("FAIL spacing_f%0d_l%0d: got %0d issues, edges %p, expected edges 1 and %0d",
               f, l, iss.size(), iss, exp_second);
    else n_pass++;
    n_checks++;
    if (bus.stall_cycles !== 16'(exp_stall))
      $display("FAIL spacing_stall_f%0d: got %0d expected %0d", f, bus.stall_cycles, exp_stall);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    spacing_run(3'd1, 4'd3, 6, 4);
    spacing_run(3'd2, 4'd0, 4, 2);
  endtask

  task automatic test_mem_full();
    apply_reset();
    bus.mem_full = 1'b1;
    set_in(1'b1, 3'd4, 4'd2, 4'd5, 5'd9);
    tick();
    bus.in_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      n_checks++;
      if ({bus.ins_nop, bus.in_ready} !== 2'b11)
        $display("FAIL memfull_hold %0d: got nop=%0d rdy=%0d expected 1 1", k, bus.ins_nop, bus.in_ready);
      else n_pass++;
    end
    bus.mem_full = 1'b0;
    tick();
    n_checks++;
    if ({bus.ins_nop, bus.func_select, bus.rob_entry} !== {1'b0, 3'd4, 4'd5})
      $display("FAIL memfull_release: got nop=%0d func=%0d rob=%0d expected 0 4 5",
               bus.ins_nop, bus.func_select, bus.rob_entry);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    int r = 0;
    int robs[$];
    int edges[$];
    bit ok;
    bit was_ready;
    apply_reset();
    bus.alu_free = 4'b1011;
    for (int k = 0; k < 8 && r < 4; k++) begin
      set_in(1'b1, (r == 0) ? 3'd2 : 3'd0, 4'd1, 4'(r), 5'(r));
      was_ready = bus.in_ready;
      tick();
      if (was_ready) r++;
    end
    set_in(1'b1, 3'd0, 4'd1, 4'd4, 5'd4);
    n_checks++;
    if (bus.in_ready !== 1'b0) $display("FAIL bp_full: got in_ready=%0d expected 0", bus.in_ready);
    else n_pass++;
    bus.alu_free = 4'hF;
    for (int k = 0; k < 10; k++) begin
      bus.in_valid = (r < 5);
      was_ready = bus.in_ready;
      tick();
      if (was_ready && r < 5) r++;
      if (bus.ins_nop === 1'b0) begin
        robs.push_back(int'(bus.rob_entry));
        edges.push_back(k);
      end
    end
    ok = (robs.size() == 5);
    for (int i = 0; i < robs.size() && ok; i++)
      if (robs[i] != i || edges[i] != edges[0] + i) ok = 1'b0;
    n_checks++;
    if (!ok) $display("FAIL bp_order: got robs %p at edges %p, expected 0..4 consecutive", robs, edges);
    else n_pass++;
  endtask

  task automatic test_flush();
    int issued = 0;
    apply_reset();
    bus.alu_free = 4'h0;
    for (int k = 0; k < 3; k++) begin
      set_in(1'b1, 3'd0, 4'd1, 4'(k + 1), 5'(k));
      tick();
    end
    set_in(1'b1, 3'd0, 4'd1, 4'd9, 5'd9);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    n_checks++;
    if ({bus.ins_nop, bus.in_ready} !== 2'b11)
      $display("FAIL flush_state: got nop=%0d rdy=%0d expected 1 1", bus.ins_nop, bus.in_ready);
    else n_pass++;
    bus.alu_free = 4'hF;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (bus.ins_nop === 1'b0) issued++;
    end
    n_checks++;
    if (issued != 0) $display("FAIL flush_drop: got %0d issues after flush, expected 0", issued);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    int issued = 0;
    apply_reset();
    bus.alu_free = 4'b1101;
    set_in(1'b1, 3'd1, 4'd2, 4'd1, 5'd1); tick();
    set_in(1'b1, 3'd1, 4'd2, 4'd2, 5'd2); tick();
    set_in(1'b1, 3'd1, 4'd2, 4'd3, 5'd3); tick();
    bus.in_valid = 1'b0;
    bus.alu_free = 4'hF;
    tick();
    n_checks++;
    if ({bus.ins_nop, bus.func_select, bus.rob_entry} !== {1'b0, 3'd1, 4'd1})
      $display("FAIL areset_pre: got nop=%0d func=%0d rob=%0d expected 0 1 1",
               bus.ins_nop, bus.func_select, bus.rob_entry);
    else n_pass++;
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if ({bus.func_select, bus.ins_nop, bus.in_ready, bus.rob_entry, bus.latency_counter,
         bus.stall_cycles} !== {DUMMY, 1'b1, 1'b1, 4'd0, 4'd0, 16'd0})
      $display("FAIL areset_immediate: got func=%0d nop=%0d rdy=%0d rob=%0d lat=%0d stall=%0d expected 5 1 1 0 0 0",
               bus.func_select, bus.ins_nop, bus.in_ready, bus.rob_entry, bus.latency_counter,
               bus.stall_cycles);
    else n_pass++;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    set_in(1'b1, 3'd1, 4'd2, 4'd11, 5'd4);
    tick();
    bus.in_valid = 1'b0;
    tick();
    n_checks++;
    if ({bus.ins_nop, bus.rob_entry} !== {1'b0, 4'd11})
      $display("FAIL areset_no_busy: got nop=%0d rob=%0d expected 0 11", bus.ins_nop, bus.rob_entry);
    else n_pass++;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (bus.ins_nop === 1'b0) issued++;
    end
    n_checks++;
    if (issued != 0) $display("FAIL areset_dropped: got %0d stale issues, expected 0", issued);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [15:0] exp_stall;
    apply_reset();
    for (int c = 0; c < 800; c++) begin
      set_in(($urandom_range(0, 9) < 6), 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
             4'($urandom), 5'($urandom));
      bus.alu_free = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
                      ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)};
      bus.mem_full = ($urandom_range(0, 4) == 0);
      bus.flush    = ($urandom_range(0, 39) == 0);
      tick();
      exp_stall = 16'(m_stall);
      n_checks++;
      if ({bus.func_select, bus.ins_nop, bus.latency_counter, bus.rob_entry, bus.dest_reg,
           bus.in_ready, bus.stall_cycles} !==
          {e_func, e_nop, e_lat, e_rob, e_dest, (mq.size() < FIFO_DEPTH), exp_stall})
        $display("FAIL rand_ctrl cyc %0d: got func=%0d nop=%0d lat=%0d rob=%0d dest=%0d rdy=%0d stall=%0d expected %0d %0d %0d %0d %0d %0d %0d",
                 c, bus.func_select, bus.ins_nop, bus.latency_counter, bus.rob_entry, bus.dest_reg,
                 bus.in_ready, bus.stall_cycles, e_func, e_nop, e_lat, e_rob, e_dest,
                 (mq.size() < FIFO_DEPTH), exp_stall);
      else n_pass++;
      n_checks++;
      if (bus.payload !== e_payload)
        $display("FAIL rand_payload cyc %0d: got %h expected %h", c, bus.payload, e_payload);
      else n_pass++;
    end
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    model_reset();
    test_reset();
    test_basic_issue();
    test_back_to_back();
    test_mem_full();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
